// File: rtl/text_pkg.sv
// Shared types and default geometry for the text-mode renderer.
package text_pkg;

  localparam int DEF_H_CHARS      = 80;
  localparam int DEF_V_CHARS      = 30;
  localparam int DEF_GLYPH_W      = 8;
  localparam int DEF_GLYPH_H      = 16;
  localparam int DEF_BLINK_FRAMES = 30;

  // Layout of one 16-bit character cell inside a VRAM word half.
  localparam int CHAR_W        = 16;
  localparam int ATTR_INV_BIT  = 15;
  localparam int ATTR_CODE_LSB = 8;
  localparam int ATTR_FG_LSB   = 4;
  localparam int ATTR_BG_LSB   = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic       invert;
    logic [6:0] code;
    logic [3:0] fg;
    logic [3:0] bg;
  } char_attr_t;

  function automatic char_attr_t unpack_char(input logic [CHAR_W-1:0] w);
    char_attr_t a;
    a.invert = w[ATTR_INV_BIT];
    a.code   = w[ATTR_CODE_LSB +: 7];
    a.fg     = w[ATTR_FG_LSB +: 4];
    a.bg     = w[ATTR_BG_LSB +: 4];
    return a;
  endfunction

endpackage

// File: rtl/text_palette.sv
// 16-entry RGB444 palette: one synchronous write port, two combinational read ports.
module text_palette
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] widx,
  input  rgb444_t    wdata,
  input  logic [3:0] fg_idx,
  input  logic [3:0] bg_idx,
  output rgb444_t    fg_rgb,
  output rgb444_t    bg_rgb
);

  rgb444_t pal_r [16];

  // Palette storage; a write becomes visible to readers on the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) pal_r[i] <= '0;
    end else if (we) begin
      pal_r[widx] <= wdata;
    end
  end

  assign fg_rgb = pal_r[fg_idx];
  assign bg_rgb = pal_r[bg_idx];

endmodule

// File: rtl/text_pixel_pipeline.sv
// Text-mode renderer: pixel position -> VRAM cell -> font row -> palette colour,
// three registered stages with sync/blank delayed to match.
module text_pixel_pipeline
  import text_pkg::*;
#(
  parameter int H_CHARS      = DEF_H_CHARS,
  parameter int V_CHARS      = DEF_V_CHARS,
  parameter int GLYPH_W      = DEF_GLYPH_W,
  parameter int GLYPH_H      = DEF_GLYPH_H,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter int VRAM_AW      = $clog2(H_CHARS*V_CHARS/2),
  parameter int FONT_AW      = $clog2(128*GLYPH_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         drawX,
  input  logic [9:0]         drawY,
  input  logic               vde,
  input  logic               hsync,
  input  logic               vsync,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [31:0]        vram_rdata,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [GLYPH_W-1:0] font_data,
  input  logic               pal_we,
  input  logic [3:0]         pal_idx,
  input  logic [11:0]        pal_wdata,
  input  logic               cursor_en,
  input  logic [6:0]         cursor_col,
  input  logic [4:0]         cursor_row,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               vde_o
);

  localparam int XW   = $clog2(GLYPH_W);
  localparam int YW   = $clog2(GLYPH_H);
  localparam int IW   = VRAM_AW + 1;
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);

  logic [9:0]      col_s, row_s;
  logic [IW-1:0]   idx_s;
  logic            active_s, cursor_hit_s;
  char_attr_t      attr_s;
  logic            pix_bit_s, pixel_on_s;
  rgb444_t         fg_rgb_s, bg_rgb_s, colour_s;

  logic            vsync_prev_r, blink_phase_r;
  logic [FC_W-1:0] frame_cnt_r;

  logic            half0_r, cur0_r, act0_r;
  logic [XW-1:0]   xoff0_r;
  logic [YW-1:0]   yoff0_r;
  logic [2:0]      sync0_r;

  logic            inv1_r, cur1_r, act1_r;
  logic [3:0]      fg1_r, bg1_r;
  logic [XW-1:0]   xoff1_r;
  logic [FONT_AW-1:0] font_addr_r;
  logic [2:0]      sync1_r;

  rgb444_t         rgb_r;
  logic [2:0]      sync2_r;

  assign col_s        = drawX / 10'(GLYPH_W);
  assign row_s        = drawY / 10'(GLYPH_H);
  assign idx_s        = IW'(16'(row_s) * 16'(H_CHARS) + 16'(col_s));
  assign vram_addr    = idx_s[IW-1:1];
  assign active_s     = vde && (drawX < 10'(H_CHARS*GLYPH_W)) && (drawY < 10'(V_CHARS*GLYPH_H));
  assign cursor_hit_s = cursor_en && (col_s == 10'(cursor_col)) && (row_s == 10'(cursor_row))
                        && blink_phase_r;

  // Frame counter advances once per vsync rising edge, toggling the blink phase on wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_prev_r  <= 1'b0;
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else begin
      vsync_prev_r <= vsync;
      if (vsync && !vsync_prev_r) begin
        if (frame_cnt_r == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_r   <= '0;
          blink_phase_r <= ~blink_phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + FC_W'(1);
        end
      end
    end
  end

  // Stage 0: capture in-cell offsets and per-pixel flags while VRAM is read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half0_r <= 1'b0;
      xoff0_r <= '0;
      yoff0_r <= '0;
      cur0_r  <= 1'b0;
      act0_r  <= 1'b0;
      sync0_r <= '0;
    end else begin
      half0_r <= idx_s[0];
      xoff0_r <= XW'(drawX % 10'(GLYPH_W));
      yoff0_r <= YW'(drawY % 10'(GLYPH_H));
      cur0_r  <= cursor_hit_s;
      act0_r  <= active_s;
      sync0_r <= {hsync, vsync, vde};
    end
  end

  assign attr_s = unpack_char(half0_r ? vram_rdata[2*CHAR_W-1:CHAR_W] : vram_rdata[CHAR_W-1:0]);

  // Stage 1: pick the character half-word and form the glyph-row address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      font_addr_r <= '0;
      inv1_r      <= 1'b0;
      fg1_r       <= '0;
      bg1_r       <= '0;
      xoff1_r     <= '0;
      cur1_r      <= 1'b0;
      act1_r      <= 1'b0;
      sync1_r     <= '0;
    end else begin
      font_addr_r <= FONT_AW'(attr_s.code) * FONT_AW'(GLYPH_H) + FONT_AW'(yoff0_r);
      inv1_r      <= attr_s.invert;
      fg1_r       <= attr_s.fg;
      bg1_r       <= attr_s.bg;
      xoff1_r     <= xoff0_r;
      cur1_r      <= cur0_r;
      act1_r      <= act0_r;
      sync1_r     <= sync0_r;
    end
  end

  assign font_addr = font_addr_r;

  text_palette u_palette (
    .clk    (clk),
    .reset  (reset),
    .we     (pal_we),
    .widx   (pal_idx),
    .wdata  (rgb444_t'(pal_wdata)),
    .fg_idx (fg1_r),
    .bg_idx (bg1_r),
    .fg_rgb (fg_rgb_s),
    .bg_rgb (bg_rgb_s)
  );

  assign pix_bit_s  = font_data[XW'(GLYPH_W - 1) - xoff1_r];
  assign pixel_on_s = pix_bit_s ^ inv1_r ^ cur1_r;

  // Stage 2 colour select; blanking forces black.
  always_comb begin
    colour_s = '0;
    if (!act1_r) begin
      colour_s = '0;
    end else if (pixel_on_s) begin
      colour_s = fg_rgb_s;
    end else begin
      colour_s = bg_rgb_s;
    end
  end

  // Stage 2: register the final pixel and the matching timing signals.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r   <= '0;
      sync2_r <= '0;
    end else begin
      rgb_r   <= colour_s;
      sync2_r <= sync1_r;
    end
  end

  assign red                       = rgb_r.r;
  assign green                     = rgb_r.g;
  assign blue                      = rgb_r.b;
  assign {hsync_o, vsync_o, vde_o} = sync2_r;

endmodule
